mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and data memory access (DM), using a req/ack handshake with variable latency.
- Sits between the fetch/MEM pipeline stages and the memory model.
- Produces stall requests that are ORed into the pipeline stall/flush logic alongside the load-use and branch stalls.
- Sequences one memory transaction at a time through a small FSM, with an optional fairness mode and a watchdog.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- FAIR, 0: 0 = DM always wins; 1 = alternate grants when IF and DM are both pending.
- TIMEOUT, 255: max cycles spent in a busy state before abort; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; level, held until if_done
- if_addr  in  AW  fetch address; stable while if_req
- if_rdata  out  DW  fetched word; valid in the if_done cycle, held until next IF completion
- if_done  out  1  one-cycle completion pulse
- stall_if  out  1  = if_req & ~if_done (combinational)
- dm_req  in  1  data request; level, held until dm_done
- dm_we  in  1  1 = store
- dm_be  in  4  store byte enables
- dm_addr  in  AW  data address
- dm_wd  in  DW  store data
- dm_rdata  out  DW  load data; valid in the dm_done cycle, held until next DM completion
- dm_done  out  1  one-cycle completion pulse
- stall_dm  out  1  = dm_req & ~dm_done (combinational)
- mem_req  out  1  memory request (registered)
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory
- err  out  1  sticky watchdog-timeout flag

Behaviour:
- FSM states: IDLE, DM_BUSY, IF_BUSY, DONE. Reset → IDLE.
- Reset values: all outputs 0, including rdata registers, counter and last_grant (0 = IF).
- IDLE sampling:
  - dm_req only → latch dm_we/be/addr/wd into the mem_* registers, mem_req = 1, go to DM_BUSY.
  - if_req only → mem_we = 0, mem_be = 4'hF, mem_addr = if_addr, go to IF_BUSY.
  - Both pending, FAIR = 0 → DM.
  - Both pending, FAIR = 1 → the requester opposite last_grant.
  - last_grant is updated on every grant.
- mem_req rises the cycle after the grant decision. It and all mem_* outputs stay constant until mem_ack is sampled high.
- On mem_ack in a BUSY state:
  - Next cycle: mem_req = 0, state = DONE.
  - The matching *_rdata register captures mem_rdata; writes capture nothing.
  - The matching *_done pulses for exactly that DONE cycle.
- DONE:
  - No requests are sampled, which avoids re-granting a request the pipeline is still retiring.
  - Always go to IDLE next.
- Latency: request seen in IDLE at cycle t with memory ack at t+1+L (L ≥ 0) → *_done at t+2+L. Minimum is 3 cycles request-to-done.
- mem_ack while in IDLE or DONE (stale, e.g. after reset) is ignored.
- Watchdog:
  - The counter clears on entry to a BUSY state and increments each BUSY cycle.
  - On reaching TIMEOUT without mem_ack: set err (sticky until rst), drop mem_req, go to DONE, pulse the matching done with rdata = 0.
- Requests dropping before done (e.g. pipeline flush) do not abort an in-flight transaction. It completes normally and done pulses regardless.
- Reset mid-transaction: the next cycle is IDLE with mem_req = 0, and the outstanding ack is discarded.
- Never more than one mem transaction in flight. mem_req never re-asserts in the cycle immediately after an ack.

Test Plan:
- IF-only read, memory acks 2 cycles after mem_req:
  - if_req = 1 with if_addr = 0x0040_0000 at cycle 0 → mem_req = 1 cycles 1–3, mem_we = 0, mem_be = F.
  - mem_rdata = 0x2408_0005 captured; if_done = 1 at cycle 4 only; stall_if = 1 cycles 0–3.
- DM store:
  - dm_we = 1, dm_be = 4'b0011, dm_addr = 0x1000_0004, dm_wd = 0xCAFE_BABE → mem_* match exactly for the whole request.
  - dm_done pulses once; dm_rdata unchanged.
- Simultaneous if_req and dm_req, FAIR = 0:
  - DM is granted first, IF next.
  - Total 6 cycles with 0-latency acks; if_done occurs 3 cycles after dm_done.
- Both requesters held continuously, FAIR = 1 → grants alternate DM, IF, DM, IF…, with last_grant = IF after reset so DM is granted first.
- Memory never acks, TIMEOUT = 8:
  - mem_req drops after 8 busy cycles, err = 1, done pulses with rdata = 0.
  - err stays 1 through later good transactions until rst.
- rst asserted while in DM_BUSY, then a stale mem_ack the next cycle:
  - mem_req = 0 after reset, no done pulse.
  - State returns to IDLE and the stale ack is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified-memory port arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          stall_if;

    logic          dm_req;
    logic          dm_we;
    logic [3:0]    dm_be;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wd;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          stall_dm;

    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          err;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wd,
        input  mem_rdata, mem_ack,
        output if_rdata, if_done, stall_if,
        output dm_rdata, dm_done, stall_dm,
        output mem_req, mem_we, mem_be, mem_addr, mem_wd,
        output err
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_be, dm_addr, dm_wd,
        output mem_rdata, mem_ack,
        input  if_rdata, if_done, stall_if,
        input  dm_rdata, dm_done, stall_dm,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wd,
        input  err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data access, one transaction at a time.
// Request-to-done is 2 cycles plus memory latency (min 3); requesters stall via stall_if/stall_dm until done.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int FAIR    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;   // 1 = DM owned the latest grant
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;

    logic grant_dm, grant_if;
    logic busy, ack_hit, timeout;
    logic if_done, dm_done;

    assign busy    = (state_q == DM_BUSY) || (state_q == IF_BUSY);
    assign ack_hit = busy && bus.mem_ack;
    // An ack arriving in the final watchdog cycle still wins over the abort.
    assign timeout = busy && !bus.mem_ack && ((cnt_q + 8'd1) == TIMEOUT_C);

    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
            if (bus.dm_req && bus.if_req) begin
                grant_dm = (FAIR != 0) ? ~last_grant_q : 1'b1;
                grant_if = ~grant_dm;
            end else begin
                grant_dm = bus.dm_req;
                grant_if = bus.if_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d = DM_BUSY;
                end else if (grant_if) begin
                    state_d = IF_BUSY;
                end
            end
            DM_BUSY, IF_BUSY: begin
                if (ack_hit || timeout) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_done = 1'b0;
        dm_done = 1'b0;
        if (state_q == DONE) begin
            dm_done = last_grant_q;
            if_done = ~last_grant_q;
        end
    end

    always_comb begin
        cnt_d        = busy ? (cnt_q + 8'd1) : 8'd0;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        err_d        = err_q;

        if (grant_dm) begin
            mem_req_d    = 1'b1;
            mem_we_d     = bus.dm_we;
            mem_be_d     = bus.dm_be;
            mem_addr_d   = bus.dm_addr;
            mem_wd_d     = bus.dm_wd;
            last_grant_d = 1'b1;
        end else if (grant_if) begin
            mem_req_d    = 1'b1;
            mem_we_d     = 1'b0;
            mem_be_d     = 4'hF;
            mem_addr_d   = bus.if_addr;
            last_grant_d = 1'b0;
        end

        if (ack_hit || timeout) begin
            mem_req_d = 1'b0;
            if (state_q == DM_BUSY) begin
                if (timeout) begin
                    dm_rdata_d = '0;
                end else if (!mem_we_q) begin
                    dm_rdata_d = bus.mem_rdata;
                end
            end else begin
                if_rdata_d = timeout ? '0 : bus.mem_rdata;
            end
        end

        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 8'd0;
            last_grant_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.if_done  = if_done;
    assign bus.dm_done  = dm_done;
    assign bus.stall_if = bus.if_req & ~if_done;
    assign bus.stall_dm = bus.dm_req & ~dm_done;
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_be   = mem_be_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: b0/u_dut0 runs strict DM priority, b1/u_dut1 runs fair alternation; both use an 8-cycle watchdog.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) b0 ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) b1 ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .FAIR(0), .TIMEOUT(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .FAIR(1), .TIMEOUT(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        b0.if_req = 1'b0; b0.if_addr = '0;
        b0.dm_req = 1'b0; b0.dm_we = 1'b0; b0.dm_be = 4'h0; b0.dm_addr = '0; b0.dm_wd = '0;
        b0.mem_ack = 1'b0; b0.mem_rdata = '0;
        b1.if_req = 1'b0; b1.if_addr = '0;
        b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_be = 4'h0; b1.dm_addr = '0; b1.dm_wd = '0;
        b1.mem_ack = 1'b0; b1.mem_rdata = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        b0.mem_ack = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        b0.mem_ack = 1'b0;
        #1;
        total_cnt++;
        if ({b0.mem_req, b0.if_done, b0.dm_done, b0.err, b0.stall_if, b0.stall_dm} !== 6'b0)
            $display("FAIL reset_ctl0 got=%b exp=000000",
                     {b0.mem_req, b0.if_done, b0.dm_done, b0.err, b0.stall_if, b0.stall_dm});
        else pass_cnt++;
        total_cnt++;
        if ({b0.if_rdata, b0.dm_rdata} !== 64'h0)
            $display("FAIL reset_rdata0 got=%h exp=0", {b0.if_rdata, b0.dm_rdata});
        else pass_cnt++;
        total_cnt++;
        if ({b0.mem_we, b0.mem_be, b0.mem_addr, b0.mem_wd} !== 69'h0)
            $display("FAIL reset_membus0 got=%h exp=0", {b0.mem_we, b0.mem_be, b0.mem_addr, b0.mem_wd});
        else pass_cnt++;
        total_cnt++;
        if ({b1.mem_req, b1.if_done, b1.dm_done, b1.err} !== 4'b0)
            $display("FAIL reset_ctl1 got=%b exp=0000", {b1.mem_req, b1.if_done, b1.dm_done, b1.err});
        else pass_cnt++;
    endtask

    task automatic test_if_read();
        logic [2:0] exp;
        drive_idle();
        for (int c = 0; c <= 5; c++) begin
            tick();
            b0.if_req    = (c <= 4);
            b0.if_addr   = 32'h0040_0000;
            b0.mem_ack   = (c == 3);
            b0.mem_rdata = (c == 3) ? 32'h2408_0005 : 32'hDEAD_BEEF;
            #1;
            case (c)
                0:       exp = 3'b001;
                1, 2, 3: exp = 3'b101;
                4:       exp = 3'b010;
                default: exp = 3'b000;
            endcase
            total_cnt++;
            if ({b0.mem_req, b0.if_done, b0.stall_if} !== exp)
                $display("FAIL if_read_ctl c%0d req/done/stall got=%b exp=%b",
                         c, {b0.mem_req, b0.if_done, b0.stall_if}, exp);
            else pass_cnt++;
            if (c >= 1 && c <= 3) begin
                total_cnt++;
                if ({b0.mem_we, b0.mem_be, b0.mem_addr} !== {1'b0, 4'hF, 32'h0040_0000})
                    $display("FAIL if_read_bus c%0d got=%h exp=%h", c,
                             {b0.mem_we, b0.mem_be, b0.mem_addr}, {1'b0, 4'hF, 32'h0040_0000});
                else pass_cnt++;
            end
            if (c >= 4) begin
                total_cnt++;
                if (b0.if_rdata !== 32'h2408_0005)
                    $display("FAIL if_read_rdata c%0d got=%h exp=24080005", c, b0.if_rdata);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_dm_store();
        logic [2:0] exp;
        drive_idle();
        for (int c = 0; c <= 4; c++) begin
            tick();
            b0.dm_req    = (c <= 3);
            b0.dm_we     = 1'b1;
            b0.dm_be     = 4'b0011;
            b0.dm_addr   = 32'h1000_0004;
            b0.dm_wd     = 32'hCAFE_BABE;
            b0.mem_ack   = (c == 2);
            b0.mem_rdata = 32'h1111_1111;
            #1;
            case (c)
                0:       exp = 3'b001;
                1, 2:    exp = 3'b101;
                3:       exp = 3'b010;
                default: exp = 3'b000;
            endcase
            total_cnt++;
            if ({b0.mem_req, b0.dm_done, b0.stall_dm} !== exp)
                $display("FAIL dm_store_ctl c%0d req/done/stall got=%b exp=%b",
                         c, {b0.mem_req, b0.dm_done, b0.stall_dm}, exp);
            else pass_cnt++;
            if (c == 1 || c == 2) begin
                total_cnt++;
                if ({b0.mem_we, b0.mem_be, b0.mem_addr, b0.mem_wd} !==
                    {1'b1, 4'b0011, 32'h1000_0004, 32'hCAFE_BABE})
                    $display("FAIL dm_store_bus c%0d got=%h exp=%h", c,
                             {b0.mem_we, b0.mem_be, b0.mem_addr, b0.mem_wd},
                             {1'b1, 4'b0011, 32'h1000_0004, 32'hCAFE_BABE});
                else pass_cnt++;
            end
            if (c >= 3) begin
                total_cnt++;
                if ({b0.dm_rdata, b0.if_rdata} !== {32'h0, 32'h2408_0005})
                    $display("FAIL dm_store_rdata c%0d got=%h exp=%h", c,
                             {b0.dm_rdata, b0.if_rdata}, {32'h0, 32'h2408_0005});
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        drive_idle();
        for (int c = 0; c <= 6; c++) begin
            tick();
            b0.dm_req    = (c <= 2);
            b0.dm_we     = 1'b0;
            b0.dm_be     = 4'hF;
            b0.dm_addr   = 32'h1000_0008;
            b0.if_req    = (c <= 5);
            b0.if_addr   = 32'h0040_0004;
            b0.mem_ack   = b0.mem_req;
            b0.mem_rdata = (c == 1) ? 32'hAAAA_0001 : ((c == 4) ? 32'hBBBB_0002 : 32'h0);
            #1;
            case (c)
                0:       exp = 5'b00011;
                1:       exp = 5'b10011;
                2:       exp = 5'b01001;
                3:       exp = 5'b00001;
                4:       exp = 5'b10001;
                5:       exp = 5'b00100;
                default: exp = 5'b00000;
            endcase
            total_cnt++;
            if ({b0.mem_req, b0.dm_done, b0.if_done, b0.stall_dm, b0.stall_if} !== exp)
                $display("FAIL b2b_ctl c%0d req/dmd/ifd/sdm/sif got=%b exp=%b", c,
                         {b0.mem_req, b0.dm_done, b0.if_done, b0.stall_dm, b0.stall_if}, exp);
            else pass_cnt++;
            if (c == 1) begin
                total_cnt++;
                if ({b0.mem_we, b0.mem_addr} !== {1'b0, 32'h1000_0008})
                    $display("FAIL b2b_dm_bus got=%h exp=%h", {b0.mem_we, b0.mem_addr}, {1'b0, 32'h1000_0008});
                else pass_cnt++;
            end
            if (c == 4) begin
                total_cnt++;
                if ({b0.mem_we, b0.mem_be, b0.mem_addr} !== {1'b0, 4'hF, 32'h0040_0004})
                    $display("FAIL b2b_if_bus got=%h exp=%h",
                             {b0.mem_we, b0.mem_be, b0.mem_addr}, {1'b0, 4'hF, 32'h0040_0004});
                else pass_cnt++;
            end
            if (c == 2) begin
                total_cnt++;
                if (b0.dm_rdata !== 32'hAAAA_0001)
                    $display("FAIL b2b_dm_rdata got=%h exp=aaaa0001", b0.dm_rdata);
                else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++;
                if (b0.if_rdata !== 32'hBBBB_0002)
                    $display("FAIL b2b_if_rdata got=%h exp=bbbb0002", b0.if_rdata);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_fair();
        logic [2:0]  exp;
        logic        dm_turn;
        int          phase;
        drive_idle();
        for (int c = 0; c <= 12; c++) begin
            tick();
            b1.dm_req    = (c <= 11);
            b1.dm_we     = 1'b0;
            b1.dm_be     = 4'hF;
            b1.dm_addr   = 32'h1000_0020;
            b1.if_req    = (c <= 11);
            b1.if_addr   = 32'h0040_0020;
            b1.mem_ack   = b1.mem_req;
            b1.mem_rdata = 32'hF000_0000 + 32'(c);
            #1;
            phase   = c % 3;
            dm_turn = (((c / 3) % 2) == 0);
            exp     = {(phase == 1), (phase == 2) && dm_turn, (phase == 2) && !dm_turn};
            total_cnt++;
            if ({b1.mem_req, b1.dm_done, b1.if_done} !== exp)
                $display("FAIL fair_ctl c%0d req/dmd/ifd got=%b exp=%b",
                         c, {b1.mem_req, b1.dm_done, b1.if_done}, exp);
            else pass_cnt++;
            if (phase == 1) begin
                total_cnt++;
                if (b1.mem_addr !== (dm_turn ? 32'h1000_0020 : 32'h0040_0020))
                    $display("FAIL fair_addr c%0d got=%h exp=%h", c, b1.mem_addr,
                             dm_turn ? 32'h1000_0020 : 32'h0040_0020);
                else pass_cnt++;
            end
            if (phase == 2) begin
                total_cnt++;
                if ((dm_turn ? b1.dm_rdata : b1.if_rdata) !== 32'hF000_0000 + 32'(c - 1))
                    $display("FAIL fair_rdata c%0d got=%h exp=%h", c,
                             dm_turn ? b1.dm_rdata : b1.if_rdata, 32'hF000_0000 + 32'(c - 1));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_timeout();
        logic [2:0] exp;
        drive_idle();
        for (int c = 0; c <= 10; c++) begin
            tick();
            b0.if_req  = (c <= 9);
            b0.if_addr = 32'h0040_0008;
            b0.mem_ack = 1'b0;
            #1;
            if (c == 0)      exp = 3'b000;
            else if (c <= 8) exp = 3'b100;
            else if (c == 9) exp = 3'b011;
            else             exp = 3'b001;
            total_cnt++;
            if ({b0.mem_req, b0.if_done, b0.err} !== exp)
                $display("FAIL timeout_ctl c%0d req/done/err got=%b exp=%b",
                         c, {b0.mem_req, b0.if_done, b0.err}, exp);
            else pass_cnt++;
            if (c == 9) begin
                total_cnt++;
                if (b0.if_rdata !== 32'h0)
                    $display("FAIL timeout_rdata got=%h exp=00000000", b0.if_rdata);
                else pass_cnt++;
            end
        end
        for (int c = 0; c <= 3; c++) begin
            tick();
            b0.if_req    = 1'b0;
            b0.dm_req    = (c <= 2);
            b0.dm_we     = 1'b0;
            b0.dm_be     = 4'hF;
            b0.dm_addr   = 32'h1000_000C;
            b0.mem_ack   = (c == 1);
            b0.mem_rdata = 32'h5555_AAAA;
            #1;
            if (c == 2) begin
                total_cnt++;
                if ({b0.dm_done, b0.err, b0.dm_rdata} !== {1'b1, 1'b1, 32'h5555_AAAA})
                    $display("FAIL sticky_err_done got=%h exp=%h",
                             {b0.dm_done, b0.err, b0.dm_rdata}, {1'b1, 1'b1, 32'h5555_AAAA});
                else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++;
                if ({b0.dm_done, b0.err} !== 2'b01)
                    $display("FAIL sticky_err_after got=%b exp=01", {b0.dm_done, b0.err});
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        for (int c = 0; c <= 7; c++) begin
            tick();
            rst          = (c == 2);
            b0.dm_req    = (c <= 2);
            b0.dm_we     = 1'b1;
            b0.dm_be     = 4'hF;
            b0.dm_addr   = 32'h1000_0010;
            b0.dm_wd     = 32'h0BAD_F00D;
            b0.mem_ack   = (c == 3) || (c == 5);
            b0.mem_rdata = 32'h7777_0000;
            b0.if_req    = (c >= 4) && (c <= 6);
            b0.if_addr   = 32'h0040_000C;
            #1;
            if (c == 1 || c == 2) begin
                total_cnt++;
                if (b0.mem_req !== 1'b1)
                    $display("FAIL rst_mid_busy c%0d mem_req got=%b exp=1", c, b0.mem_req);
                else pass_cnt++;
            end
            if (c == 3 || c == 4) begin
                total_cnt++;
                if ({b0.mem_req, b0.dm_done, b0.if_done, b0.err} !== 4'b0000)
                    $display("FAIL rst_mid_after c%0d req/dmd/ifd/err got=%b exp=0000",
                             c, {b0.mem_req, b0.dm_done, b0.if_done, b0.err});
                else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++;
                if ({b0.mem_req, b0.mem_addr} !== {1'b1, 32'h0040_000C})
                    $display("FAIL rst_mid_regrant got=%h exp=%h",
                             {b0.mem_req, b0.mem_addr}, {1'b1, 32'h0040_000C});
                else pass_cnt++;
            end
            if (c == 6) begin
                total_cnt++;
                if ({b0.if_done, b0.dm_done, b0.if_rdata} !== {1'b1, 1'b0, 32'h7777_0000})
                    $display("FAIL rst_mid_done got=%h exp=%h",
                             {b0.if_done, b0.dm_done, b0.if_rdata}, {1'b1, 1'b0, 32'h7777_0000});
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_if_read();
        test_dm_store();
        test_back_to_back();
        test_fair();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
